// File: rtl/rv32i_types.sv
// rv32i_types
// Shared RV32I scheduling types used by the compare scheduler and its bench.
//   cmp_ops_t : branch-compare opcodes, encoded as the RV32I funct3 field
//   rs_t      : one compare reservation-station slot (operands, opcode, tag)
//   sal_t     : one result as it leaves on the common data bus
package rv32i_types;

  typedef enum logic [2:0] {
    beq  = 3'b000,
    bne  = 3'b001,
    blt  = 3'b100,
    bge  = 3'b101,
    bltu = 3'b110,
    bgeu = 3'b111
  } cmp_ops_t;

  typedef struct packed {
    logic [31:0] r1;
    logic [31:0] r2;
    cmp_ops_t    cmp_opcode;
    logic [3:0]  tag;
  } rs_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  tag;
    logic        rdy;
  } sal_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Rotating-priority arbiter: grants the first requesting slot found when
// scanning from i_ptr upward, wrapping modulo SIZE.
//   i_req   : request vector, one bit per slot
//   i_ptr   : slot with highest priority this cycle
//   i_en    : grant enable; with i_en=0 no grant is produced
//   o_grant : one-hot grant (all zero when nothing granted)
//   o_idx   : index of the selected slot (meaningful when o_valid=1)
//   o_valid : a grant was produced this cycle
module rr_arbiter #(
  parameter  int SIZE = 8,
  localparam int PW   = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic [SIZE-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  input  logic            i_en,
  output logic [SIZE-1:0] o_grant,
  output logic [PW-1:0]   o_idx,
  output logic            o_valid
);

  logic          w_found;
  logic [PW-1:0] w_idx;

  // Slot reached k steps after ptr, wrapping at SIZE (SIZE need not be a
  // power of two, so plain PW-bit overflow is not enough).
  function automatic logic [PW-1:0] slotAt(input logic [PW-1:0] ptr, input int k);
    int s;
    s = int'(ptr) + k;
    if (s >= SIZE) s = s - SIZE;
    return PW'(s);
  endfunction

  // Scan from the farthest offset back toward ptr so the nearest requester
  // is the last assignment and therefore wins.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = SIZE - 1; k >= 0; k--) begin
      if (i_req[slotAt(i_ptr, k)]) begin
        w_found = 1'b1;
        w_idx   = slotAt(i_ptr, k);
      end
    end
  end

  always_comb begin
    o_grant = '0;
    if (i_en && w_found) o_grant[w_idx] = 1'b1;
  end

  assign o_idx   = w_idx;
  assign o_valid = i_en && w_found;

endmodule

// File: rtl/cmp_sched.sv
// cmp_sched
// Compare-unit scheduler: picks one ready reservation-station slot per cycle
// (round robin), evaluates its branch compare, and queues the 0/1 result in a
// small FIFO that drains onto the common data bus.
//   i_clk       : clock, all state on rising edge
//   i_rst       : asynchronous active-low reset
//   i_flush     : drop all buffered results, no issue this cycle
//   i_rs_data   : slot contents (r1, r2, cmp_opcode, tag)
//   i_rs_valid  : slot occupied with operands resolved
//   o_issue_ack : one-hot grant; the station frees that slot at the same edge
//   o_cdb_valid : buffer head holds a result
//   i_cdb_ready : bus accepts the head this cycle
//   o_cdb_out   : head result, all zero when o_cdb_valid=0
import rv32i_types::*;

module cmp_sched #(
  parameter int SIZE  = 8,
  parameter int DEPTH = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_flush,
  input  rs_t  [SIZE-1:0]      i_rs_data,
  input  logic [SIZE-1:0]      i_rs_valid,
  output logic [SIZE-1:0]      o_issue_ack,
  output logic                 o_cdb_valid,
  input  logic                 i_cdb_ready,
  output sal_t                 o_cdb_out
);

  localparam int PW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0]   r_rr_ptr;
  logic [AW-1:0]   r_head;
  logic [AW-1:0]   r_tail;
  logic [CW-1:0]   r_count;
  sal_t            r_buf [DEPTH];

  logic            w_pop;
  logic            w_issue_en;
  logic            w_push;
  logic [SIZE-1:0] w_grant;
  logic [PW-1:0]   w_idx;
  logic [PW-1:0]   w_next_ptr;
  rs_t             w_sel;
  logic            w_true;
  sal_t            w_result;

  // A pop frees a slot in the same edge, so a full buffer can still accept
  // an issue. Reset gates issue so nothing is granted while rst is low.
  assign w_pop      = (r_count != '0) && i_cdb_ready && !i_flush;
  assign w_issue_en = i_rst && !i_flush && ((r_count < CW'(DEPTH)) || w_pop);

  rr_arbiter #(.SIZE(SIZE)) u_arb (
    .i_req   (i_rs_valid),
    .i_ptr   (r_rr_ptr),
    .i_en    (w_issue_en),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_valid (w_push)
  );

  assign o_issue_ack = w_grant;
  assign w_sel       = i_rs_data[w_idx];
  assign w_next_ptr  = (w_idx == PW'(SIZE - 1)) ? '0 : w_idx + PW'(1);

  // Single shared compare unit for the granted slot; unknown opcodes give 0.
  always_comb begin
    w_true = 1'b0;
    case (w_sel.cmp_opcode)
      beq:     w_true = (w_sel.r1 == w_sel.r2);
      bne:     w_true = (w_sel.r1 != w_sel.r2);
      blt:     w_true = ($signed(w_sel.r1) <  $signed(w_sel.r2));
      bge:     w_true = ($signed(w_sel.r1) >= $signed(w_sel.r2));
      bltu:    w_true = (w_sel.r1 <  w_sel.r2);
      bgeu:    w_true = (w_sel.r1 >= w_sel.r2);
      default: w_true = 1'b0;
    endcase
  end

  assign w_result = {{31'd0, w_true}, w_sel.tag, 1'b1};

  // Control state: pointers, occupancy and arbitration pointer.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_rr_ptr <= '0;
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_tail   <= r_tail + AW'(1);
        r_rr_ptr <= w_next_ptr;
      end
      if (w_pop) r_head <= r_head + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Result storage needs no reset: entries are only read while count>0.
  always_ff @(posedge i_clk) begin
    if (w_push) r_buf[r_tail] <= w_result;
  end

  assign o_cdb_valid = (r_count != '0);
  assign o_cdb_out   = o_cdb_valid ? r_buf[r_head] : '0;

endmodule

// File: tb/tb_cmp_sched.sv
// tb_cmp_sched
// Self-checking bench for cmp_sched: directed scenarios followed by random
// traffic, all compared each cycle against a queue-based reference model.
import rv32i_types::*;

module tb_cmp_sched;

  localparam int SIZE  = 8;
  localparam int DEPTH = 4;

  logic                clk;
  logic                rst;
  logic                flush;
  rs_t  [SIZE-1:0]     rsData;
  logic [SIZE-1:0]     rsValid;
  logic [SIZE-1:0]     issueAck;
  logic                cdbValid;
  logic                cdbReady;
  sal_t                cdbOut;

  int   checks;
  int   errors;
  sal_t modelQ[$];
  int   modelPtr;
  bit   holdValid;
  logic [SIZE-1:0] obsAck;

  cmp_sched #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_flush     (flush),
    .i_rs_data   (rsData),
    .i_rs_valid  (rsValid),
    .o_issue_ack (issueAck),
    .o_cdb_valid (cdbValid),
    .i_cdb_ready (cdbReady),
    .o_cdb_out   (cdbOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural meaning of each compare opcode, using int for signed order.
  function automatic logic [31:0] refCmp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bit t;
    case (op)
      3'd0:    t = (a == b);
      3'd1:    t = (a != b);
      3'd4:    t = (int'(a) <  int'(b));
      3'd5:    t = (int'(a) >= int'(b));
      3'd6:    t = (a <  b);
      3'd7:    t = (a >= b);
      default: t = 1'b0;
    endcase
    return t ? 32'd1 : 32'd0;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic setSlot(input int s, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] tag);
    rsData[s].r1         = a;
    rsData[s].r2         = b;
    rsData[s].cmp_opcode = cmp_ops_t'(op);
    rsData[s].tag        = tag;
    rsValid[s]           = 1'b1;
  endtask

  // One clock cycle: called at a negedge with inputs already driven. Checks
  // the DUT against the model, then advances the model past the next edge.
  task automatic applyStimulus();
    int          g;
    bit          doPop;
    logic [SIZE-1:0] expAck;
    sal_t        expOut;
    sal_t        res;
    #1;
    doPop = (modelQ.size() > 0) && cdbReady && !flush;
    g = -1;
    if (!flush && ((modelQ.size() < DEPTH) || doPop)) begin
      for (int k = 0; k < SIZE; k++) begin
        if (rsValid[(modelPtr + k) % SIZE]) begin
          g = (modelPtr + k) % SIZE;
          break;
        end
      end
    end
    expAck = '0;
    if (g >= 0) expAck[g] = 1'b1;
    expOut = (modelQ.size() > 0) ? modelQ[0] : '0;
    obsAck = issueAck;
    checkOutput("issue_ack", 64'(issueAck), 64'(expAck));
    checkOutput("cdb_valid", 64'(cdbValid), 64'(modelQ.size() > 0));
    checkOutput("cdb_out",   64'(cdbOut),   64'(expOut));
    @(posedge clk);
    #1;
    if (flush) begin
      modelQ.delete();
    end else begin
      if (doPop) void'(modelQ.pop_front());
      if (g >= 0) begin
        res.data = refCmp(rsData[g].cmp_opcode, rsData[g].r1, rsData[g].r2);
        res.tag  = rsData[g].tag;
        res.rdy  = 1'b1;
        modelQ.push_back(res);
        modelPtr = (g + 1) % SIZE;
        if (!holdValid) rsValid[g] = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic pulseReset();
    rst = 1'b0;
    modelQ.delete();
    modelPtr = 0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    modelPtr  = 0;
    holdValid = 1'b0;
    flush     = 1'b0;
    cdbReady  = 1'b0;
    rsData    = '0;
    rst       = 1'b0;
    // Requests present during reset must not be granted.
    rsValid   = '1;
    #3;
    checkOutput("reset_ack",   64'(issueAck), 64'd0);
    checkOutput("reset_valid", 64'(cdbValid), 64'd0);
    checkOutput("reset_out",   64'(cdbOut),   64'd0);
    rsValid = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Single slot 3, beq 5==5, tag 6.
    setSlot(3, 3'd0, 32'd5, 32'd5, 4'h6);
    applyStimulus();
    checkOutput("slot3_ack",   64'(obsAck), 64'h08);
    checkOutput("slot3_valid", 64'(cdbValid), 64'd1);
    checkOutput("slot3_data",  64'(cdbOut.data), 64'd1);
    checkOutput("slot3_tag",   64'(cdbOut.tag), 64'h6);

    // Signed vs unsigned ordering and bge equality.
    cdbReady = 1'b1;
    setSlot(4, 3'd4, 32'hFFFF_FFFF, 32'd1, 4'h1);
    applyStimulus();
    checkOutput("blt_data", 64'(cdbOut.data), 64'd1);
    setSlot(5, 3'd6, 32'hFFFF_FFFF, 32'd1, 4'h2);
    applyStimulus();
    checkOutput("bltu_data", 64'(cdbOut.data), 64'd0);
    setSlot(6, 3'd5, 32'd7, 32'd7, 4'h3);
    applyStimulus();
    checkOutput("bge_data", 64'(cdbOut.data), 64'd1);
    applyStimulus();

    // All slots continuously valid, bus always ready: strict rotation.
    pulseReset();
    holdValid = 1'b1;
    for (int s = 0; s < SIZE; s++) setSlot(s, 3'd1, 32'(s), 32'd3, 4'(s));
    for (int i = 0; i < SIZE + 1; i++) begin
      applyStimulus();
      checkOutput($sformatf("rotate_%0d", i), 64'(obsAck), 64'(1) << (i % SIZE));
    end

    // Bus stalled: the buffer fills after exactly DEPTH issues.
    pulseReset();
    cdbReady = 1'b0;
    for (int i = 0; i <= DEPTH; i++) begin
      applyStimulus();
      checkOutput($sformatf("fill_%0d", i), 64'(obsAck), (i < DEPTH) ? (64'(1) << i) : 64'd0);
    end
    // Full buffer with the bus draining: one in, one out every cycle.
    cdbReady = 1'b1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus();
      checkOutput($sformatf("stream_ack_%0d", i), 64'(obsAck), 64'(1) << ((DEPTH + i) % SIZE));
      checkOutput($sformatf("stream_valid_%0d", i), 64'(cdbValid), 64'd1);
    end

    // Flush with three results buffered.
    pulseReset();
    holdValid = 1'b0;
    cdbReady  = 1'b0;
    rsValid   = '0;
    for (int s = 0; s < 3; s++) setSlot(s, 3'd0, 32'd1, 32'(s), 4'(8 + s));
    for (int i = 0; i < 3; i++) applyStimulus();
    setSlot(1, 3'd7, 32'd9, 32'd2, 4'hA);
    setSlot(5, 3'd1, 32'd9, 32'd2, 4'hB);
    flush = 1'b1;
    applyStimulus();
    checkOutput("flush_ack", 64'(obsAck), 64'd0);
    flush = 1'b0;
    checkOutput("flush_valid", 64'(cdbValid), 64'd0);
    applyStimulus();
    checkOutput("flush_ptr_held", 64'(obsAck), 64'h20);
    applyStimulus();

    // Asynchronous reset mid-cycle with two results buffered.
    setSlot(2, 3'd0, 32'd4, 32'd4, 4'h4);
    setSlot(6, 3'd0, 32'd4, 32'd5, 4'h5);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_valid", 64'(cdbValid), 64'd0);
    checkOutput("async_ack",   64'(issueAck), 64'd0);
    checkOutput("async_out",   64'(cdbOut),   64'd0);
    modelQ.delete();
    modelPtr = 0;
    @(negedge clk);
    rst = 1'b1;
    rsValid = '0;
    for (int s = 0; s < SIZE; s++) setSlot(s, 3'd5, 32'd1, 32'd0, 4'(s));
    applyStimulus();
    checkOutput("after_reset_grant", 64'(obsAck), 64'h01);

    // Random traffic: slots refill while free, random bus stalls and flushes.
    for (int c = 0; c < 400; c++) begin
      for (int s = 0; s < SIZE; s++) begin
        if (!rsValid[s] && ($urandom_range(0, 2) == 0)) begin
          logic [31:0] a;
          logic [31:0] b;
          b = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
          a = ($urandom_range(0, 3) == 0) ? b : (($urandom_range(0, 1) == 0) ? -b : $urandom);
          setSlot(s, 3'($urandom_range(0, 7)), a, b, 4'($urandom_range(0, 15)));
        end
      end
      cdbReady = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 24) == 0);
      applyStimulus();
    end
    flush = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmp_sched.md
CMP_SCHED -- requirements
Module: cmp_sched

Interface
REQ-001 SHALL have parameter SIZE, default 8, number of compare reservation-station slots arbitrated.
REQ-002 SHALL have parameter DEPTH, default 4, result-buffer entries (power of two).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush  input  1  discard buffered results and suppress issue this cycle.
REQ-006 SHALL have port rs_data  input  rs_t[SIZE]  slot contents (r1, r2, cmp_opcode, tag).
REQ-007 SHALL have port rs_valid  input  SIZE  slot occupied with both operands resolved.
REQ-008 SHALL have port issue_ack  output  SIZE  one-hot grant; the reservation station frees the granted slot at the same edge.
REQ-009 SHALL have port cdb_valid  output  1  buffer head holds a result.
REQ-010 SHALL have port cdb_ready  input  1  common data bus accepts the head.
REQ-011 SHALL have port cdb_out  output  sal_t  head result (data, tag, rdy).

Function
REQ-012 SHALL keep a round-robin pointer rr_ptr (clog2(SIZE) bits); the grant is the first valid slot scanning rr_ptr, rr_ptr+1, ... modulo SIZE.
REQ-013 SHALL assert at most one issue_ack bit per cycle, combinationally, and only when issue is enabled.
REQ-014 SHALL enable issue when flush=0 and (count<DEPTH or a pop occurs this cycle).
REQ-015 SHALL advance rr_ptr to (granted index+1) mod SIZE on an issue, and hold it otherwise; SIZE-1 wraps to 0.
REQ-016 SHALL evaluate the granted slot combinationally with one 1-wide compare unit: beq, bne, blt/bge signed, bltu/bgeu unsigned; data is 32'd1 if true, else 32'd0; an undefined opcode yields data 0.
REQ-017 SHALL write {data, tag of granted slot, rdy=1} into the result buffer at the issuing edge; latency from grant cycle to cdb_valid is 1 cycle when the buffer was empty.
REQ-018 SHALL drive cdb_valid = (count!=0) and cdb_out = buffer head, registered-state only (no combinational path from rs_* to cdb_*).
REQ-019 SHALL pop the head when cdb_valid and cdb_ready are both 1; cdb_ready with an empty buffer has no effect.
REQ-020 SHALL allow simultaneous push and pop, including when full, with count unchanged and FIFO order preserved.
REQ-021 SHALL hold cdb_out stable while cdb_valid=1 and cdb_ready=0.
REQ-022 SHALL, on flush, zero count, head and tail pointers at the edge, ignore cdb_ready and force issue_ack=0 that cycle; rr_ptr is held.
REQ-023 SHALL drive cdb_out with data 0, tag 0, rdy 0 whenever cdb_valid=0.

Reset
REQ-024 SHALL, while rst=0, asynchronously clear rr_ptr, count, head and tail pointers to 0.
REQ-025 SHALL during and after reset drive issue_ack=0 (gated by rst), cdb_valid=0, and cdb_out all zero.
REQ-026 SHALL discard a result being issued when reset asserts in the same cycle; buffer contents are don't-care once count=0.

Structure
REQ-027 SHALL take rs_t, sal_t and the cmp opcode enum from rv32i_types; SIZE and DEPTH remain local parameters.
REQ-028 SHALL factor the rotating-priority grant into one sub-module rr_arbiter (request vector and pointer in, one-hot grant out).
REQ-029 SHALL keep the compare evaluation inline or in the existing comparator block; no further sub-modules.

Verification
REQ-030 SHALL cover: slot 3 only valid, beq r1=r2=5, tag 4'h6 -> issue_ack=8'h08, next cycle cdb_valid=1, data 1, tag 6.
REQ-031 SHALL cover: blt r1=32'hFFFFFFFF, r2=1 -> data 1; bltu same operands -> data 0; bge r1=r2=7 -> data 1.
REQ-032 SHALL cover: all 8 slots held valid, cdb_ready=1 -> grants 0,1,...,7,0 on successive cycles.
REQ-033 SHALL cover: cdb_ready=0, slots continuously valid -> exactly 4 issues, then issue_ack=0; cdb_ready=1 -> one pop and one issue per cycle, count stays 4, tags emerge in issue order.
REQ-034 SHALL cover: 3 buffered results, flush for one cycle -> issue_ack=0 that cycle, cdb_valid=0 next cycle, rr_ptr unchanged.
REQ-035 SHALL cover: rst low mid-stream with 2 buffered -> cdb_valid and issue_ack drop without a clock edge; after release the first grant goes to slot 0.
